// File: rtl/systolic_sequencer_if.sv
// Control/readout bundle between a host and the systolic array sequencer.
// The master drives commands and readout acceptance; the slave is the sequencer.
interface systolic_sequencer_if #(
    parameter int unsigned N       = 4,
    parameter int unsigned K_WIDTH = 8
);
    localparam int unsigned RW = $clog2(N);

    logic               start;
    logic [K_WIDTH-1:0] k_len;
    logic               c_ready;

    logic               busy;
    logic               done;
    logic               array_clr;
    logic               load;
    logic [K_WIDTH:0]   step;
    logic [N-1:0]       row_en;
    logic [N-1:0]       col_en;
    logic               c_valid;
    logic [RW-1:0]      c_row;

    modport master (
        output start, k_len, c_ready,
        input  busy, done, array_clr, load, step, row_en, col_en, c_valid, c_row
    );

    modport slave (
        input  start, k_len, c_ready,
        output busy, done, array_clr, load, step, row_en, col_en, c_valid, c_row
    );
endinterface

// File: rtl/systolic_sequencer.sv
// Sequences one N x N systolic matrix-multiply pass: clear, skewed operand feed,
// accumulator drain and row-by-row result readout. All outputs are registered.
module systolic_sequencer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned N          = 4,
    parameter int unsigned K_WIDTH    = 8
) (
    input  logic                clk,
    input  logic                rst,
    systolic_sequencer_if.slave bus
);
    localparam int unsigned SW = K_WIDTH + 1;
    localparam int unsigned EW = K_WIDTH + 2;
    localparam int unsigned RW = $clog2(N);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_READ  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    // Feed covers k_len operands plus the 2N-2 cycles of row/column skew.
    localparam logic [SW-1:0] FEED_TAIL = SW'(2 * N - 3);
    localparam logic [RW-1:0] LAST_ROW  = RW'(N - 1);

    if (N < 2 || N > 16) begin : g_bad_n
        $error("systolic_sequencer: N must be in 2..16");
    end
    if (DATA_WIDTH == 0) begin : g_bad_dw
        $error("systolic_sequencer: DATA_WIDTH must be non-zero");
    end

    logic [2:0]         r_state;
    logic [K_WIDTH-1:0] r_k;
    logic [SW-1:0]      r_step;
    logic [RW-1:0]      r_c_row;
    logic               r_busy;
    logic               r_done;
    logic               r_clr;
    logic               r_load;
    logic               r_c_valid;
    logic [N-1:0]       r_row_en;
    logic [N-1:0]       r_col_en;

    logic [2:0]         w_nxt_state;
    logic [K_WIDTH-1:0] w_nxt_k;
    logic [SW-1:0]      w_nxt_step;
    logic [RW-1:0]      w_nxt_c_row;
    logic [SW-1:0]      w_last_step;
    logic [N-1:0]       w_nxt_en;

    assign w_last_step = SW'(r_k) + FEED_TAIL;

    // Next-state and counter updates.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_k     = r_k;
        w_nxt_step  = r_step;
        w_nxt_c_row = r_c_row;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.k_len != '0) begin
                        w_nxt_state = S_CLEAR;
                        w_nxt_k     = bus.k_len;
                        w_nxt_step  = '0;
                    end else begin
                        w_nxt_state = S_DONE;
                    end
                end
            end
            S_CLEAR: begin
                w_nxt_state = S_FEED;
                w_nxt_step  = '0;
            end
            S_FEED: begin
                if (r_step == w_last_step) begin
                    w_nxt_state = S_DRAIN;
                end else begin
                    w_nxt_step = r_step + SW'(1);
                end
            end
            S_DRAIN: begin
                w_nxt_state = S_READ;
                w_nxt_c_row = '0;
            end
            S_READ: begin
                if (bus.c_ready) begin
                    if (r_c_row == LAST_ROW) begin
                        w_nxt_state = S_DONE;
                    end else begin
                        w_nxt_c_row = r_c_row + RW'(1);
                    end
                end
            end
            S_DONE: begin
                w_nxt_state = S_IDLE;
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    // Row i / column j operand valid while i <= step < i + k_len during feed.
    always_comb begin
        w_nxt_en = '0;
        for (int i = 0; i < N; i++) begin
            if ((w_nxt_state == S_FEED) &&
                (EW'(w_nxt_step) >= EW'(i)) &&
                (EW'(w_nxt_step) < (EW'(i) + EW'(w_nxt_k)))) begin
                w_nxt_en[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_k       <= '0;
            r_step    <= '0;
            r_c_row   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_clr     <= 1'b0;
            r_load    <= 1'b0;
            r_c_valid <= 1'b0;
            r_row_en  <= '0;
            r_col_en  <= '0;
        end else begin
            r_state   <= w_nxt_state;
            r_k       <= w_nxt_k;
            r_step    <= w_nxt_step;
            r_c_row   <= w_nxt_c_row;
            r_busy    <= (w_nxt_state != S_IDLE);
            r_done    <= (w_nxt_state == S_DONE);
            r_clr     <= (w_nxt_state == S_CLEAR);
            r_load    <= (w_nxt_state == S_FEED);
            r_c_valid <= (w_nxt_state == S_READ);
            r_row_en  <= w_nxt_en;
            r_col_en  <= w_nxt_en;
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.array_clr = r_clr;
    assign bus.load      = r_load;
    assign bus.step      = r_step;
    assign bus.row_en    = r_row_en;
    assign bus.col_en    = r_col_en;
    assign bus.c_valid   = r_c_valid;
    assign bus.c_row     = r_c_row;
endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed and randomized bench for systolic_sequencer; expectations come from
// a cycle-offset timeline model of one pass.
module tb_systolic_sequencer;
    localparam int unsigned NN = 4;
    localparam int unsigned KW = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    systolic_sequencer_if #(.N(NN), .K_WIDTH(KW)) bus ();

    systolic_sequencer #(.DATA_WIDTH(32), .N(NN), .K_WIDTH(KW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Operand valid for lane i at feed step s when i <= s < i + k.
    function automatic logic [NN-1:0] exp_en(input int s, input int k);
        logic [NN-1:0] e;
        e = '0;
        for (int i = 0; i < NN; i++) e[i] = (s >= i) && (s < i + k);
        return e;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_busy"},    32'(bus.busy), 0);
        check({tag, "_done"},    32'(bus.done), 0);
        check({tag, "_clr"},     32'(bus.array_clr), 0);
        check({tag, "_load"},    32'(bus.load), 0);
        check({tag, "_cvalid"},  32'(bus.c_valid), 0);
        check({tag, "_row_en"},  32'(bus.row_en), 0);
        check({tag, "_col_en"},  32'(bus.col_en), 0);
    endtask

    // mode 0: c_ready high; 1: stall 5 cycles at row 2; 2: random c_ready.
    task automatic run_pass(input int k, input int mode, input bit inject);
        int  d;
        int  r;
        int  stalls;
        int  guard;
        logic rdy;
        bus.k_len   = KW'(k);
        bus.start   = 1'b1;
        bus.c_ready = 1'b1;
        tick();
        bus.start = 1'b0;
        d = 1;
        check("clr_busy", 32'(bus.busy), 1);
        check("clr_clr",  32'(bus.array_clr), 1);
        check("clr_load", 32'(bus.load), 0);
        check("clr_step", 32'(bus.step), 0);
        check("clr_en",   32'(bus.row_en), 0);
        for (int s = 0; s < k + 2 * NN - 2; s++) begin
            bus.k_len = KW'($urandom);
            tick();
            d++;
            check("feed_load",   32'(bus.load), 1);
            check("feed_clr",    32'(bus.array_clr), 0);
            check("feed_step",   32'(bus.step), 32'(s));
            check("feed_row_en", 32'(bus.row_en), 32'(exp_en(s, k)));
            check("feed_col_en", 32'(bus.col_en), 32'(exp_en(s, k)));
            check("feed_cvalid", 32'(bus.c_valid), 0);
            check("feed_done",   32'(bus.done), 0);
        end
        tick();
        d++;
        check("drain_load",   32'(bus.load), 0);
        check("drain_busy",   32'(bus.busy), 1);
        check("drain_cvalid", 32'(bus.c_valid), 0);
        check("drain_en",     32'(bus.row_en), 0);
        tick();
        d++;
        r = 0;
        stalls = 0;
        guard = 0;
        while (r < NN && guard < 500) begin
            check("read_cvalid", 32'(bus.c_valid), 1);
            check("read_crow",   32'(bus.c_row), 32'(r));
            check("read_load",   32'(bus.load), 0);
            check("read_done",   32'(bus.done), 0);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = !((r == 2) && (stalls < 5));
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.c_ready = rdy;
            if (inject && r == 1) begin
                bus.start = 1'b1;
                bus.k_len = KW'($urandom);
            end
            tick();
            d++;
            bus.start = 1'b0;
            if (rdy) r++;
            else stalls++;
            guard++;
        end
        bus.c_ready = 1'b1;
        check("read_rows",  32'(r), NN);
        check("done_pulse", 32'(bus.done), 1);
        check("done_busy",  32'(bus.busy), 1);
        check("done_cycle", 32'(d), 32'(k + 3 * NN + 1 + stalls));
        if (mode == 1) check("stall_count", 32'(stalls), 5);
        tick();
        check_idle("post");
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b0;
        bus.start   = 1'b0;
        bus.k_len   = '0;
        bus.c_ready = 1'b1;
        tick();
        tick();
        check_idle("reset");
        check("reset_step", 32'(bus.step), 0);
        check("reset_crow", 32'(bus.c_row), 0);
        rst = 1'b1;

        run_pass(3, 0, 1'b0);
        run_pass(3, 1, 1'b0);

        // Zero-length pass: straight to DONE, no clear or load.
        bus.k_len = '0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("k0_busy", 32'(bus.busy), 1);
        check("k0_done", 32'(bus.done), 1);
        check("k0_load", 32'(bus.load), 0);
        check("k0_clr",  32'(bus.array_clr), 0);
        tick();
        check_idle("k0_after");

        // Asynchronous reset in the middle of the feed phase.
        bus.k_len = 8'd3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("abort_step_before", 32'(bus.step), 5);
        #2;
        rst = 1'b0;
        #1;
        check_idle("abort_async");
        check("abort_step", 32'(bus.step), 0);
        check("abort_crow", 32'(bus.c_row), 0);
        tick();
        check("abort_nodone", 32'(bus.done), 0);
        tick();
        check("abort_nodone2", 32'(bus.done), 0);
        rst = 1'b1;
        run_pass(3, 0, 1'b0);

        run_pass(255, 0, 1'b1);

        for (int t = 0; t < 4; t++) begin
            run_pass($urandom_range(1, 12), 2, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
